aperture_map_ctl: RTL and testbench

Controller for the A8 memory-aperture block at page $D6. It holds the per-aperture register file written through $D600-$D6FF, and sequences recomputation of the 256-bit page map. The page map tells the bus monitor which A8 pages are sourced by the FPGA and so drive EXTSEL. The bus monitor drives it with a single-cycle write strobe and the low address/data bytes; it returns the page map and a readback port for downstream aperture engines.

---
 rtl/aperture_map_ctl.sv | 169 ++++++++++++++++
 tb/tb_aperture_map_ctl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aperture_map_ctl.sv
// Aperture register file for A8 page $D6 plus the sequencer that rebuilds the
// 256-bit page map one page per cycle after each control-register commit.
module aperture_map_ctl #(
  parameter int unsigned  NUM_AP         = 4,
  parameter logic [255:0] FIXED_PAGE_MAP = 256'h40
) (
  input  logic         clk200,
  input  logic         a8_rst,
  input  logic         wr_stb,
  input  logic [7:0]   wr_addr,
  input  logic [7:0]   wr_data,
  input  logic [7:0]   rd_addr,
  output logic [7:0]   rd_data,
  output logic [255:0] page_map,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam logic [3:0] OffStart = 4'h4;
  localparam logic [3:0] OffCount = 4'h5;
  localparam logic [3:0] OffCtrl  = 4'hF;

  logic [7:0]   regs_q [NUM_AP][16];
  logic [7:0]   snap_start_q [NUM_AP];
  logic [7:0]   snap_count_q [NUM_AP];
  logic [NUM_AP-1:0] snap_en_q;

  state_e       state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         pending_q, pending_d;
  logic [255:0] shadow_q, shadow_d;
  logic [255:0] page_map_q, page_map_d;
  logic [7:0]   rd_data_q;

  logic [NUM_AP-1:0] wr_sel;
  logic         commit;
  logic         load_snap;
  logic         page_hit;
  logic [7:0]   rd_byte;
  logic [7:0]   fwd_start [NUM_AP];
  logic [7:0]   fwd_count [NUM_AP];
  logic [NUM_AP-1:0] fwd_en;

  // Writes to indices at or above NUM_AP match no wr_sel bit and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_AP; i++) begin
      wr_sel[i] = wr_stb && (wr_addr[7:4] == 4'(i));
    end
  end

  assign commit = (|wr_sel) && (wr_addr[3:0] == OffCtrl);

  // Snapshot sees the byte being written on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_AP; i++) begin
      fwd_start[i] = (wr_sel[i] && wr_addr[3:0] == OffStart) ? wr_data : regs_q[i][OffStart];
      fwd_count[i] = (wr_sel[i] && wr_addr[3:0] == OffCount) ? wr_data : regs_q[i][OffCount];
      fwd_en[i]    = (wr_sel[i] && wr_addr[3:0] == OffCtrl) ? wr_data[0] : regs_q[i][OffCtrl][0];
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_AP; i++) begin
      if (rd_addr[7:4] == 4'(i)) begin
        rd_byte = regs_q[i][rd_addr[3:0]];
      end
    end
  end

  // 9-bit end bound: no wrap past $FF, count of zero covers nothing.
  always_comb begin
    page_hit = 1'b0;
    for (int i = 0; i < NUM_AP; i++) begin
      if (snap_en_q[i] && (idx_q >= snap_start_q[i]) &&
          ({1'b0, idx_q} < ({1'b0, snap_start_q[i]} + {1'b0, snap_count_q[i]}))) begin
        page_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    page_map_d = page_map_q;
    load_snap  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          load_snap = 1'b1;
          idx_d     = 8'd0;
          busy_d    = 1'b1;
          state_d   = StSweep;
        end
      end
      StSweep: begin
        shadow_d[idx_q] = page_hit;
        if (commit) begin
          pending_d = 1'b1;
        end
        if (idx_q == 8'hFF) begin
          page_map_d = {page_hit, shadow_q[254:0]} | FIXED_PAGE_MAP;
          if (pending_q || commit) begin
            load_snap = 1'b1;
            idx_d     = 8'd0;
            pending_d = 1'b0;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk200) begin
    if (a8_rst) begin
      for (int i = 0; i < NUM_AP; i++) begin
        for (int j = 0; j < 16; j++) begin
          regs_q[i][j] <= 8'h00;
        end
        snap_start_q[i] <= 8'h00;
        snap_count_q[i] <= 8'h00;
      end
      snap_en_q  <= '0;
      state_q    <= StIdle;
      idx_q      <= 8'd0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      page_map_q <= FIXED_PAGE_MAP;
      rd_data_q  <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_AP; i++) begin
        if (wr_sel[i]) begin
          regs_q[i][wr_addr[3:0]] <= wr_data;
        end
        if (load_snap) begin
          snap_start_q[i] <= fwd_start[i];
          snap_count_q[i] <= fwd_count[i];
        end
      end
      if (load_snap) begin
        snap_en_q <= fwd_en;
      end
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      page_map_q <= page_map_d;
      rd_data_q  <= rd_byte;
    end
  end

  assign rd_data  = rd_data_q;
  assign page_map = page_map_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_aperture_map_ctl.sv
// Scoreboard bench for aperture_map_ctl: expected maps/readbacks are queued at
// stimulus time from a bench register model and compared when the DUT delivers.
`timescale 1ns/1ps
module tb_aperture_map_ctl;

  logic         clk200;
  logic         a8_rst;
  logic         wr_stb;
  logic [7:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [7:0]   rd_addr;
  logic [7:0]   rd_data;
  logic [255:0] page_map;
  logic         busy;

  aperture_map_ctl #(
    .NUM_AP        (4),
    .FIXED_PAGE_MAP(256'h40)
  ) dut (
    .clk200  (clk200),
    .a8_rst  (a8_rst),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .page_map(page_map),
    .busy    (busy)
  );

  initial clk200 = 1'b0;
  always #2.5 clk200 = ~clk200;

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] exp_q [$];
  logic [7:0]   mreg [4][16];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++)
        mreg[i][j] = 8'h00;
  endtask

  function automatic logic [255:0] model_map();
    logic [255:0] m;
    m = 256'h40;
    for (int p = 0; p < 256; p++)
      for (int i = 0; i < 4; i++)
        if (mreg[i][15][0] && p >= int'(mreg[i][4]) && p < int'(mreg[i][4]) + int'(mreg[i][5]))
          m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [255:0] pop_exp(input string tag);
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
      n_errors++;
      return '0;
    end
    return exp_q.pop_front();
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk200);
    wr_stb  = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (int'(a[7:4]) < 4) mreg[int'(a[7:4])][int'(a[3:0])] = d;
    @(negedge clk200);
    wr_stb = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a);
    logic [255:0] e;
    @(negedge clk200);
    rd_addr = a;
    exp_q.push_back((int'(a[7:4]) < 4) ? {248'd0, mreg[int'(a[7:4])][int'(a[3:0])]} : 256'd0);
    @(negedge clk200);
    e = pop_exp(tag);
    check_val(tag, {248'd0, rd_data}, e);
  endtask

  // Called at the negedge right after the committing edge.
  task automatic run_sweep(input string tag, input int exp_cycles);
    logic [255:0] old_map;
    logic [255:0] e;
    int  cnt;
    bit  changed;
    old_map = page_map;
    cnt     = 0;
    changed = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      if (page_map !== old_map) changed = 1;
      @(negedge clk200);
    end
    check_val({tag, "_busy_len"}, cnt, exp_cycles);
    check_val({tag, "_stable"}, {255'd0, changed}, 256'd0);
    e = pop_exp(tag);
    check_val({tag, "_map"}, page_map, e);
  endtask

  logic [255:0] prev_map;
  logic [255:0] e_tmp;
  logic [7:0]   wa [4];
  logic [7:0]   wd [4];
  int           wc [4];
  int           cnt;

  initial begin
    a8_rst  = 1'b1;
    wr_stb  = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    rd_addr = 8'h00;
    model_reset();
    repeat (3) @(negedge clk200);
    check_val("rst_map", page_map, 256'h40);
    check_val("rst_busy", {255'd0, busy}, 256'd0);
    check_val("rst_rd", {248'd0, rd_data}, 256'd0);
    a8_rst = 1'b0;
    rd_check("rst_rd_d605", 8'h05);

    // Single aperture.
    wr(8'h04, 8'h40);
    wr(8'h05, 8'h04);
    wr(8'h0F, 8'h01);
    exp_q.push_back(model_map());
    run_sweep("ap0", 256);
    check_val("ap0_const", page_map, 256'h40 | (256'hF << 64));
    rd_check("rd_ap0_start", 8'h04);

    // Overlap then disable ap0.
    wr(8'h14, 8'h42);
    wr(8'h15, 8'h04);
    wr(8'h1F, 8'h01);
    exp_q.push_back(model_map());
    run_sweep("ap01", 256);
    wr(8'h0F, 8'h00);
    exp_q.push_back(model_map());
    run_sweep("ap0_off", 256);
    check_val("ap0_off_const", page_map, 256'h40 | (256'hF << 66));

    // Top-of-range clip and zero count.
    wr(8'h24, 8'hFE);
    wr(8'h25, 8'h05);
    wr(8'h2F, 8'h01);
    exp_q.push_back(model_map());
    run_sweep("clip", 256);
    e_tmp = page_map;
    check_val("clip_top", {254'd0, e_tmp[255:254]}, 256'd3);
    check_val("clip_nowrap", {253'd0, e_tmp[2:0]}, 256'd0);
    prev_map = page_map;
    wr(8'h34, 8'h10);
    wr(8'h35, 8'h00);
    wr(8'h3F, 8'h01);
    exp_q.push_back(model_map());
    run_sweep("cnt0", 256);
    check_val("cnt0_same", page_map, prev_map);

    // Same-cycle write and read of one byte returns the old value.
    @(negedge clk200);
    rd_addr = 8'h06;
    wr_stb  = 1'b1;
    wr_addr = 8'h06;
    wr_data = 8'h33;
    exp_q.push_back({248'd0, mreg[0][6]});
    mreg[0][6] = 8'h33;
    @(negedge clk200);
    wr_stb = 1'b0;
    e_tmp  = pop_exp("rw_old");
    check_val("rw_old", {248'd0, rd_data}, e_tmp);
    exp_q.push_back({248'd0, mreg[0][6]});
    @(negedge clk200);
    e_tmp = pop_exp("rw_new");
    check_val("rw_new", {248'd0, rd_data}, e_tmp);

    // Commits during a sweep merge into a single follow-on sweep.
    wr(8'h04, 8'h80);
    wr(8'h05, 8'h02);
    wr(8'h0F, 8'h01);
    exp_q.push_back(model_map());
    wc = '{45, 50, 55, 60};
    wa = '{8'h04, 8'h0F, 8'h04, 8'h0F};
    wd = '{8'h90, 8'h01, 8'hA0, 8'h01};
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      wr_stb = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (cnt == wc[j]) begin
          wr_stb  = 1'b1;
          wr_addr = wa[j];
          wr_data = wd[j];
          mreg[0][int'(wa[j][3:0])] = wd[j];
        end
      end
      if (cnt == 60) exp_q.push_back(model_map());
      if (cnt == 257) begin
        e_tmp = pop_exp("pend_first");
        check_val("pend_first_map", page_map, e_tmp);
      end
      @(negedge clk200);
    end
    wr_stb = 1'b0;
    check_val("pend_busy_len", cnt, 512);
    e_tmp = pop_exp("pend_final");
    check_val("pend_final_map", page_map, e_tmp);

    // Index beyond NUM_AP is ignored.
    prev_map = page_map;
    wr(8'h40, 8'h55);
    wr(8'h4F, 8'h01);
    check_val("oob_busy", {255'd0, busy}, 256'd0);
    check_val("oob_map", page_map, prev_map);
    rd_check("oob_rd40", 8'h40);
    rd_check("oob_rd4f", 8'h4F);
    rd_check("oob_rd00", 8'h00);

    // Reset in the middle of a sweep.
    wr(8'h0F, 8'h01);
    repeat (99) @(negedge clk200);
    check_val("mid_busy", {255'd0, busy}, 256'd1);
    a8_rst = 1'b1;
    @(negedge clk200);
    a8_rst = 1'b0;
    model_reset();
    check_val("midrst_map", page_map, 256'h40);
    check_val("midrst_busy", {255'd0, busy}, 256'd0);
    rd_check("midrst_rd04", 8'h04);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
